// File: rtl/ball_serve_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : ball_serve_ctrl_if
// Purpose   : Groups the game-flow controller's control and status signals.
//             The master side (collision/input logic, display/link side)
//             drives start, frame_tick, hit, miss and miss_side, and observes
//             the status outputs. The slave side (the controller) does the
//             opposite.
// Signals   : start, frame_tick, hit, miss, miss_side       master -> slave
//             value_select, load_en, serve_side, score_a,
//             score_b, rally_cnt, game_over, state_dbg     slave -> master
// Revision  : 1.0  initial release
// ============================================================================
interface ball_serve_ctrl_if #(
  parameter int SCORE_W = 5
);
  logic               start;
  logic               frame_tick;
  logic               hit;
  logic               miss;
  logic               miss_side;
  logic               value_select;
  logic               load_en;
  logic               serve_side;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic [7:0]         rally_cnt;
  logic               game_over;
  logic [2:0]         state_dbg;

  modport master (
    output start, frame_tick, hit, miss, miss_side,
    input  value_select, load_en, serve_side, score_a, score_b,
           rally_cnt, game_over, state_dbg
  );

  modport slave (
    input  start, frame_tick, hit, miss, miss_side,
    output value_select, load_en, serve_side, score_a, score_b,
           rally_cnt, game_over, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/ball_serve_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : ball_serve_ctrl
// Purpose   : Game-flow controller for the ball-update datapath. Selects
//             between random serve values (value_select=0) and physics
//             feedback (value_select=1), strobes the ball registers, and
//             keeps score, serve side and rally count.
// Ports     : clk         system clock
//             rst_n       asynchronous active-low reset
//             ctrl_if     ball_serve_ctrl_if.slave
//               start, frame_tick, hit, miss, miss_side      (in)
//               value_select, load_en, serve_side, score_a,
//               score_b, rally_cnt, game_over, state_dbg     (out, registered)
// Params    : WIN_SCORE   points needed to win
//             SERVE_DELAY frame ticks between point end and next serve (>=1)
//             SCORE_W     score width, WIN_SCORE < 2**SCORE_W
// Macro     : DEUCE_EN    when defined, a win also needs a 2-point lead and
//                         tied scores at or above WIN_SCORE fall back to
//                         WIN_SCORE-1 each.
// Revision  : 1.0  initial release
// ============================================================================
module ball_serve_ctrl #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 60,
  parameter int SCORE_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  ball_serve_ctrl_if.slave ctrl_if
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SERVE = 3'd2,
    S_RALLY = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam int                 c_CNT_W    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W:0]   c_WIN      = (SCORE_W + 1)'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] c_RELOAD   = SCORE_W'(WIN_SCORE - 1);

  state_t             state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic [7:0]         rally_q, rally_d;
  logic               serve_q, serve_d;
  logic               parity_q, parity_d;    // odd/even total points
  logic               scorer_q, scorer_d;    // 0 = A scored, 1 = B scored
  logic               sel_q, sel_d;
  logic               load_q, load_d;
  logic               over_q, over_d;

  // Post-increment scores, one bit wider so the win compare cannot wrap.
  logic [SCORE_W:0]   w_sum_a;
  logic [SCORE_W:0]   w_sum_b;
  logic               w_win;
  logic               w_reload;

  assign w_sum_a = {1'b0, score_a_q} + {{SCORE_W{1'b0}}, ~scorer_q};
  assign w_sum_b = {1'b0, score_b_q} + {{SCORE_W{1'b0}},  scorer_q};

`ifdef DEUCE_EN
  assign w_win    = ((w_sum_a >= c_WIN) && (w_sum_a >= w_sum_b + (SCORE_W + 1)'(2))) ||
                    ((w_sum_b >= c_WIN) && (w_sum_b >= w_sum_a + (SCORE_W + 1)'(2)));
  // Tie at deuce: fold back so the counters stay bounded.
  assign w_reload = (w_sum_a == w_sum_b) && (w_sum_a >= c_WIN);
`else
  assign w_win    = (w_sum_a >= c_WIN) || (w_sum_b >= c_WIN);
  assign w_reload = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    rally_d   = rally_q;
    serve_d   = serve_q;
    parity_d  = parity_q;
    scorer_d  = scorer_q;

    case (state_q)
      S_IDLE: begin
        if (ctrl_if.start) begin
          state_d   = S_WAIT;
          cnt_d     = '0;
          score_a_d = '0;
          score_b_d = '0;
          rally_d   = '0;
          serve_d   = 1'b0;
          parity_d  = 1'b0;
        end
      end

      S_WAIT: begin
        if (ctrl_if.frame_tick) begin
          if (cnt_q == c_CNT_LAST) begin
            state_d = S_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_SERVE: begin
        state_d = S_RALLY;
        rally_d = '0;
      end

      S_RALLY: begin
        // A miss ends the rally and takes priority over a coincident hit.
        if (ctrl_if.miss) begin
          state_d  = S_POINT;
          scorer_d = ~ctrl_if.miss_side;
        end else if (ctrl_if.hit && (rally_q != 8'hFF)) begin
          rally_d = rally_q + 8'd1;
        end
      end

      S_POINT: begin
        parity_d = ~parity_q;
        if (parity_q) begin
          serve_d = ~serve_q;
        end
        if (w_reload) begin
          score_a_d = c_RELOAD;
          score_b_d = c_RELOAD;
        end else begin
          score_a_d = w_sum_a[SCORE_W-1:0];
          score_b_d = w_sum_b[SCORE_W-1:0];
        end
        state_d = w_win ? S_OVER : S_WAIT;
      end

      S_OVER: begin
        if (ctrl_if.start) begin
          state_d   = S_WAIT;
          score_a_d = '0;
          score_b_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    // A tick seen in SERVE or RALLY loads on the following cycle, unless the
    // rally ended on that same cycle.
    sel_d  = (state_d == S_RALLY);
    load_d = (state_d == S_SERVE) || ((state_d == S_RALLY) && ctrl_if.frame_tick);
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      score_a_q <= '0;
      score_b_q <= '0;
      rally_q   <= '0;
      serve_q   <= 1'b0;
      parity_q  <= 1'b0;
      scorer_q  <= 1'b0;
      sel_q     <= 1'b0;
      load_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      rally_q   <= rally_d;
      serve_q   <= serve_d;
      parity_q  <= parity_d;
      scorer_q  <= scorer_d;
      sel_q     <= sel_d;
      load_q    <= load_d;
      over_q    <= over_d;
    end
  end

  assign ctrl_if.value_select = sel_q;
  assign ctrl_if.load_en      = load_q;
  assign ctrl_if.serve_side   = serve_q;
  assign ctrl_if.score_a      = score_a_q;
  assign ctrl_if.score_b      = score_b_q;
  assign ctrl_if.rally_cnt    = rally_q;
  assign ctrl_if.game_over    = over_q;
  assign ctrl_if.state_dbg    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_serve_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : tb_ball_serve_ctrl
// Purpose   : Self-checking bench for ball_serve_ctrl. Scores, serve side and
//             win status come from a game-level model (point counts and the
//             scoring rules); load strobes and rally counts come from the
//             driven tick/hit sequences. Honours DEUCE_EN like the design.
// Revision  : 1.0  initial release
// ============================================================================
module tb_ball_serve_ctrl;
  localparam int WIN_SCORE   = 11;
  localparam int SERVE_DELAY = 3;
  localparam int SCORE_W     = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Game-level reference model.
  int mdl_a    = 0;
  int mdl_b    = 0;
  int mdl_pts  = 0;
  bit mdl_over = 1'b0;

  ball_serve_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  ball_serve_ctrl #(
    .WIN_SCORE  (WIN_SCORE),
    .SERVE_DELAY(SERVE_DELAY),
    .SCORE_W    (SCORE_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctrl_if(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.start      = 1'b0;
    bus.frame_tick = 1'b0;
    bus.hit        = 1'b0;
    bus.miss       = 1'b0;
    bus.miss_side  = 1'b0;
  endtask

  task automatic model_reset();
    mdl_a = 0; mdl_b = 0; mdl_pts = 0; mdl_over = 1'b0;
  endtask

  task automatic model_point(input bit b_scores);
    if (b_scores) mdl_b++; else mdl_a++;
    mdl_pts++;
`ifdef DEUCE_EN
    if (mdl_a == mdl_b && mdl_a >= WIN_SCORE) begin
      mdl_a = WIN_SCORE - 1;
      mdl_b = WIN_SCORE - 1;
    end
    mdl_over = (mdl_a >= WIN_SCORE && mdl_a - mdl_b >= 2) ||
               (mdl_b >= WIN_SCORE && mdl_b - mdl_a >= 2);
`else
    mdl_over = (mdl_a >= WIN_SCORE) || (mdl_b >= WIN_SCORE);
`endif
  endtask

  // {score_a, score_b, serve_side, game_over}
  function automatic logic [2*SCORE_W+1:0] exp_board();
    bit sv;
    sv = ((mdl_pts / 2) % 2) == 1;
    return {SCORE_W'(mdl_a), SCORE_W'(mdl_b), sv, mdl_over};
  endfunction

  function automatic logic [2*SCORE_W+1:0] dut_board();
    return {bus.score_a, bus.score_b, bus.serve_side, bus.game_over};
  endfunction

  function automatic logic [63:0] dut_all();
    return 64'({bus.value_select, bus.load_en, bus.serve_side, bus.score_a,
                bus.score_b, bus.rally_cnt, bus.game_over, bus.state_dbg});
  endfunction

  // From WAIT: ticks every 4 clk until SERVE appears (bounded), then one
  // more cycle into RALLY.
  task automatic serve_to_rally(output bit ok, output int nticks,
                                output bit load_at_serve, output bit sel_at_serve);
    ok = 1'b0; nticks = 0; load_at_serve = 1'b0; sel_at_serve = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      bus.frame_tick = ((i % 4) == 3);
      if (bus.frame_tick) nticks++;
      cyc();
      bus.frame_tick = 1'b0;
      if (bus.state_dbg == 3'd2) begin
        ok = 1'b1;
        load_at_serve = bus.load_en;
        sel_at_serve  = bus.value_select;
      end
    end
    if (ok) cyc();
  endtask

  // Full point: serve, nhits hits, miss by the loser, through POINT.
  task automatic play_point(input bit b_scores, input int nhits, output bit ok);
    int n; bit l, s;
    serve_to_rally(ok, n, l, s);
    for (int i = 0; i < nhits; i++) begin
      bus.hit = 1'b1; cyc(); bus.hit = 1'b0;
    end
    bus.miss = 1'b1; bus.miss_side = ~b_scores;
    cyc();
    quiet();
    cyc();
    model_point(b_scores);
  endtask

  task automatic test_reset();
    quiet();
    rst_n = 1'b0;
    repeat (3) cyc();
    total++;
    if (dut_all() !== 64'd0) begin
      bad++; $display("FAIL reset_values: got %h want 0", dut_all());
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.frame_tick = 1'($urandom_range(0, 1));
      bus.hit        = 1'($urandom_range(0, 1));
      bus.miss       = 1'($urandom_range(0, 1));
      cyc();
      total++;
      if (bus.state_dbg !== 3'd0 || bus.load_en !== 1'b0) begin
        bad++; $display("FAIL idle_ignore: state=%0d load=%0d want 0/0", bus.state_dbg, bus.load_en);
      end
    end
    quiet();
    bus.start = 1'b1; cyc(); quiet();
    total++;
    if (bus.state_dbg !== 3'd1 || dut_board() !== '0) begin
      bad++; $display("FAIL start_to_wait: state=%0d board=%h want 1/0", bus.state_dbg, dut_board());
    end
  endtask

  task automatic test_serve();
    bit ok; int n; bit l, s;
    serve_to_rally(ok, n, l, s);
    total++;
    if (!ok || n !== SERVE_DELAY) begin
      bad++; $display("FAIL serve_delay: reached=%0d ticks=%0d want 1/%0d", ok, n, SERVE_DELAY);
    end
    total++;
    if (l !== 1'b1 || s !== 1'b0) begin
      bad++; $display("FAIL serve_cycle: load=%0d sel=%0d want 1/0", l, s);
    end
    total++;
    if (bus.state_dbg !== 3'd3 || bus.value_select !== 1'b1 || bus.load_en !== 1'b0 || bus.rally_cnt !== 8'd0) begin
      bad++; $display("FAIL rally_entry: state=%0d sel=%0d load=%0d rally=%0d want 3/1/0/0",
                      bus.state_dbg, bus.value_select, bus.load_en, bus.rally_cnt);
    end
  endtask

  task automatic test_rally_score();
    bit ok;
    bus.hit = 1'b1; repeat (5) cyc(); bus.hit = 1'b0;
    total++;
    if (bus.rally_cnt !== 8'd5) begin
      bad++; $display("FAIL rally_5hits: got %0d want 5", bus.rally_cnt);
    end
    bus.miss = 1'b1; bus.miss_side = 1'b0; cyc(); quiet();
    total++;
    if (bus.state_dbg !== 3'd4 || bus.rally_cnt !== 8'd5) begin
      bad++; $display("FAIL miss_to_point: state=%0d rally=%0d want 4/5", bus.state_dbg, bus.rally_cnt);
    end
    cyc();
    model_point(1'b1);
    total++;
    if (dut_board() !== exp_board() || bus.state_dbg !== 3'd1) begin
      bad++; $display("FAIL first_point: board=%h state=%0d want %h/1", dut_board(), bus.state_dbg, exp_board());
    end
    play_point(1'b0, 2, ok);
    total++;
    if (!ok || dut_board() !== exp_board() || bus.serve_side !== 1'b1) begin
      bad++; $display("FAIL second_point_serve: board=%h want %h", dut_board(), exp_board());
    end
  endtask

  task automatic test_rally_random();
    bit ok, l, s, t, h, b; int n; int exp_r;
    serve_to_rally(ok, n, l, s);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rand_serve: serve not reached got 0 want 1");
    end
    exp_r = 0;
    for (int i = 0; i < 40; i++) begin
      t = ($urandom_range(0, 3) == 0);
      h = 1'($urandom_range(0, 1));
      bus.frame_tick = t; bus.hit = h;
      cyc(); quiet();
      if (h && exp_r < 255) exp_r++;
      total++;
      if (bus.load_en !== t || bus.rally_cnt !== 8'(exp_r) || bus.value_select !== 1'b1) begin
        bad++; $display("FAIL rand_rally cyc %0d: load=%0d rally=%0d sel=%0d want %0d/%0d/1",
                        i, bus.load_en, bus.rally_cnt, bus.value_select, t, exp_r);
      end
    end
    b = 1'($urandom_range(0, 1));
    bus.frame_tick = 1'b1; bus.miss = 1'b1; bus.miss_side = ~b;
    cyc(); quiet();
    total++;
    if (bus.state_dbg !== 3'd4 || bus.load_en !== 1'b0 || bus.value_select !== 1'b0 || bus.rally_cnt !== 8'(exp_r)) begin
      bad++; $display("FAIL miss_tick_noload: state=%0d load=%0d sel=%0d rally=%0d want 4/0/0/%0d",
                      bus.state_dbg, bus.load_en, bus.value_select, bus.rally_cnt, exp_r);
    end
    cyc();
    model_point(b);
    total++;
    if (dut_board() !== exp_board() || bus.state_dbg !== 3'd1) begin
      bad++; $display("FAIL rand_point: board=%h state=%0d want %h/1", dut_board(), bus.state_dbg, exp_board());
    end
  endtask

  task automatic test_saturate_hit_miss();
    bit ok, l, s; int n;
    serve_to_rally(ok, n, l, s);
    bus.hit = 1'b1; repeat (260) cyc(); bus.hit = 1'b0;
    total++;
    if (!ok || bus.rally_cnt !== 8'd255) begin
      bad++; $display("FAIL rally_saturate: got %0d want 255", bus.rally_cnt);
    end
    bus.hit = 1'b1; bus.miss = 1'b1; bus.frame_tick = 1'b1; bus.miss_side = 1'b0;
    cyc(); quiet();
    total++;
    if (bus.state_dbg !== 3'd4 || bus.rally_cnt !== 8'd255 || bus.load_en !== 1'b0) begin
      bad++; $display("FAIL hit_miss_same: state=%0d rally=%0d load=%0d want 4/255/0",
                      bus.state_dbg, bus.rally_cnt, bus.load_en);
    end
    cyc();
    model_point(1'b1);
    total++;
    if (dut_board() !== exp_board()) begin
      bad++; $display("FAIL sat_point: board=%h want %h", dut_board(), exp_board());
    end
  endtask

  task automatic test_random_game();
    bit ok, b;
    for (int p = 0; p < 80 && !mdl_over; p++) begin
      b = 1'($urandom_range(0, 1));
      play_point(b, int'($urandom_range(0, 3)), ok);
      total++;
      if (!ok || dut_board() !== exp_board() || bus.state_dbg !== (mdl_over ? 3'd5 : 3'd1)) begin
        bad++; $display("FAIL game_point %0d: board=%h state=%0d want %h/%0d",
                        p, dut_board(), bus.state_dbg, exp_board(), mdl_over ? 5 : 1);
      end
    end
    for (int i = 0; i < 10; i++) begin
      bus.frame_tick = 1'($urandom_range(0, 1));
      bus.hit        = 1'($urandom_range(0, 1));
      bus.miss       = 1'($urandom_range(0, 1));
      cyc(); quiet();
      total++;
      if (bus.state_dbg !== 3'd5 || bus.load_en !== 1'b0 || bus.value_select !== 1'b0 ||
          dut_board() !== exp_board()) begin
        bad++; $display("FAIL over_hold: state=%0d load=%0d sel=%0d board=%h want 5/0/0/%h",
                        bus.state_dbg, bus.load_en, bus.value_select, dut_board(), exp_board());
      end
    end
    bus.start = 1'b1; cyc(); quiet();
    mdl_a = 0; mdl_b = 0; mdl_over = 1'b0;
    total++;
    if (bus.state_dbg !== 3'd1 || dut_board() !== exp_board()) begin
      bad++; $display("FAIL over_restart: state=%0d board=%h want 1/%h", bus.state_dbg, dut_board(), exp_board());
    end
  endtask

  task automatic test_win();
    bit ok;
    bit seq[$];
    rst_n = 1'b0; cyc(); rst_n = 1'b1; model_reset();
    bus.start = 1'b1; cyc(); quiet();
`ifdef DEUCE_EN
    for (int i = 0; i < 20; i++) seq.push_back(i % 2 == 1);
    seq.push_back(1'b0); seq.push_back(1'b1); seq.push_back(1'b0); seq.push_back(1'b0);
`else
    for (int i = 0; i < WIN_SCORE; i++) seq.push_back(1'b0);
`endif
    foreach (seq[k]) begin
      play_point(seq[k], 1, ok);
      total++;
      if (!ok || dut_board() !== exp_board() || bus.state_dbg !== (mdl_over ? 3'd5 : 3'd1)) begin
        bad++; $display("FAIL win_seq %0d: board=%h state=%0d want %h/%0d",
                        k, dut_board(), bus.state_dbg, exp_board(), mdl_over ? 5 : 1);
      end
    end
    total++;
    if (bus.game_over !== 1'b1) begin
      bad++; $display("FAIL win_game_over: got %0d want 1", bus.game_over);
    end
    bus.start = 1'b1; cyc(); quiet();
    total++;
    if (bus.state_dbg !== 3'd1 || bus.score_a !== '0 || bus.score_b !== '0 || bus.game_over !== 1'b0) begin
      bad++; $display("FAIL win_restart: state=%0d a=%0d b=%0d over=%0d want 1/0/0/0",
                      bus.state_dbg, bus.score_a, bus.score_b, bus.game_over);
    end
  endtask

  task automatic test_reset_mid_rally();
    bit ok, l, s; int n;
    serve_to_rally(ok, n, l, s);
    bus.hit = 1'b1; repeat (3) cyc(); bus.hit = 1'b0;
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1 bus.frame_tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (!ok || dut_all() !== 64'd0) begin
      bad++; $display("FAIL async_reset: got %h want 0", dut_all());
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      bus.frame_tick = 1'($urandom_range(0, 1));
      bus.hit        = 1'($urandom_range(0, 1));
      cyc(); quiet();
      total++;
      if (bus.state_dbg !== 3'd0 || bus.load_en !== 1'b0) begin
        bad++; $display("FAIL post_reset_idle: state=%0d load=%0d want 0/0", bus.state_dbg, bus.load_en);
      end
    end
    bus.start = 1'b1; cyc(); quiet();
    total++;
    if (bus.state_dbg !== 3'd1) begin
      bad++; $display("FAIL post_reset_start: state=%0d want 1", bus.state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_rally_score();
    test_rally_random();
    test_saturate_hit_miss();
    test_random_game();
    test_win();
    test_reset_mid_rally();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
